// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 blocks.
// Contents: key/round constants, byte/word typedefs, the key-schedule FSM
// state enum and the round-constant (rcon) lookup.
// Optional macro: AES_KEY_SCHEDULE_ROUND_KEY_STORE_EN adds the PRECALC state.
package aes_pkg;

    localparam int AES_KEY_W = 128;
    localparam int AES_NR    = 10;

    typedef logic [7:0]  aes_byte_t;
    typedef logic [31:0] aes_word_t;

`ifdef AES_KEY_SCHEDULE_ROUND_KEY_STORE_EN
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EMIT    = 2'd1,
        ST_PRECALC = 2'd2
    } ks_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1
    } ks_state_t;
`endif

    // Round constant for producing round key i (valid for i = 1..10).
    function automatic aes_byte_t aes_rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: one byte in, its substitution out.
// Ports:
//   data : input byte
//   sub  : S-box substitution of data
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] data,
    output logic [7:0] sub
);

    // Entry 0x00 sits in the top byte, so entry x starts at bit 8*(255-x).
    localparam logic [2047:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // 255 - data == ~data, times 8 via the appended zeros.
    assign sub = SBOX[{~data, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES-128 key expansion. Emits the 11 round keys one per
// valid/ready handshake from a single 128-bit working register.
// Optional macro: AES_KEY_SCHEDULE_ROUND_KEY_STORE_EN adds an 11x128 key
// store and a reverse (decryption-order) emission mode.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   start, key       : begin expansion of key (accepted only when idle)
//   reverse          : emit keys 10..0 (store build only, sampled with start)
//   round_key        : current round key, w0 in [127:96]
//   round_key_valid  : round_key/round_idx valid
//   round_key_ready  : consumer accepts the key this cycle
//   round_idx        : index of round_key (0..10)
//   busy             : not idle
//   done             : one-cycle pulse after the last key is accepted
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    input  logic         reverse,
    output logic [127:0] round_key,
    output logic         round_key_valid,
    input  logic         round_key_ready,
    output logic [3:0]   round_idx,
    output logic         busy,
    output logic         done
);

    if (NR != AES_NR) begin : g_nr_check
        $error("aes_key_schedule supports only NR = 10");
    end

    localparam logic [3:0] LAST_IDX = 4'(AES_NR);

    ks_state_t      state, state_nxt;
    logic [127:0]   rk_q;
    logic [3:0]     idx_q;
    logic           done_q;
    logic           load, fwd_step, fin, last;
    logic [127:0]   rk_next;

    aes_word_t      w0, w1, w2, w3, rot, subw, t;
    aes_word_t      n0, n1, n2, n3;

    // Next round key from the working register.
    assign w0  = rk_q[127:96];
    assign w1  = rk_q[95:64];
    assign w2  = rk_q[63:32];
    assign w3  = rk_q[31:0];
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sub
        aes_sbox u_sbox (
            .data (rot[8*b +: 8]),
            .sub  (subw[8*b +: 8])
        );
    end

    assign t       = subw ^ {aes_rcon(idx_q + 4'd1), 24'h000000};
    assign n0      = w0 ^ t;
    assign n1      = w1 ^ n0;
    assign n2      = w2 ^ n1;
    assign n3      = w3 ^ n2;
    assign rk_next = {n0, n1, n2, n3};

`ifdef AES_KEY_SCHEDULE_ROUND_KEY_STORE_EN
    logic           rev_q;
    logic           rev_step;
    logic [127:0]   store [0:AES_NR];

    assign last = rev_q ? (idx_q == 4'd0) : (idx_q == LAST_IDX);
`else
    logic           unused_reverse;

    assign unused_reverse = reverse;
    assign last           = (idx_q == LAST_IDX);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        fwd_step  = 1'b0;
        fin       = 1'b0;
`ifdef AES_KEY_SCHEDULE_ROUND_KEY_STORE_EN
        rev_step  = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ST_EMIT;
`ifdef AES_KEY_SCHEDULE_ROUND_KEY_STORE_EN
                    if (reverse) begin
                        state_nxt = ST_PRECALC;
                    end
`endif
                end
            end
            ST_EMIT: begin
                if (round_key_ready) begin
                    if (last) begin
                        fin       = 1'b1;
                        state_nxt = ST_IDLE;
                    end
`ifdef AES_KEY_SCHEDULE_ROUND_KEY_STORE_EN
                    else if (rev_q) begin
                        rev_step = 1'b1;
                    end
`endif
                    else begin
                        fwd_step = 1'b1;
                    end
                end
            end
`ifdef AES_KEY_SCHEDULE_ROUND_KEY_STORE_EN
            // Silent expansion: after the step from index 9 the working
            // register already holds key 10, which is the first emitted.
            ST_PRECALC: begin
                fwd_step = 1'b1;
                if (idx_q == LAST_IDX - 4'd1) begin
                    state_nxt = ST_EMIT;
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rk_q   <= '0;
            idx_q  <= '0;
            done_q <= 1'b0;
`ifdef AES_KEY_SCHEDULE_ROUND_KEY_STORE_EN
            rev_q  <= 1'b0;
`endif
        end else begin
            done_q <= fin;
            if (load) begin
                rk_q  <= key;
                idx_q <= 4'd0;
`ifdef AES_KEY_SCHEDULE_ROUND_KEY_STORE_EN
                rev_q <= reverse;
`endif
            end else if (fwd_step) begin
                rk_q  <= rk_next;
                idx_q <= idx_q + 4'd1;
            end
`ifdef AES_KEY_SCHEDULE_ROUND_KEY_STORE_EN
            else if (rev_step) begin
                rk_q  <= store[idx_q - 4'd1];
                idx_q <= idx_q - 4'd1;
            end
`endif
        end
    end

`ifdef AES_KEY_SCHEDULE_ROUND_KEY_STORE_EN
    // Key store is pure data; every entry is written before it is read.
    always_ff @(posedge clk) begin
        if (load) begin
            store[0] <= key;
        end else if (fwd_step) begin
            store[idx_q + 4'd1] <= rk_next;
        end
    end
`endif

    assign round_key       = rk_q;
    assign round_idx       = idx_q;
    assign round_key_valid = (state == ST_EMIT);
    assign busy            = (state != ST_IDLE);
    assign done            = done_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
module tb_aes_key_schedule;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key;
    logic         reverse;
    logic [127:0] round_key;
    logic         round_key_valid;
    logic         round_key_ready;
    logic [3:0]   round_idx;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    aes_key_schedule #(.NR(10)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .key             (key),
        .reverse         (reverse),
        .round_key       (round_key),
        .round_key_valid (round_key_valid),
        .round_key_ready (round_key_ready),
        .round_idx       (round_idx),
        .busy            (busy),
        .done            (done)
    );

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] rk;
        bit           full;
    } vec_t;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    vec_t vt [2][11];
    vec_t sb [$];
    int   errors = 0;
    int   checks = 0;

`ifdef AES_KEY_SCHEDULE_ROUND_KEY_STORE_EN
    localparam bit EXP_REV = 1'b1;
    localparam int EXP_REV_LAT = 10;
`else
    localparam bit EXP_REV = 1'b0;
    localparam int EXP_REV_LAT = 0;
`endif

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Drives one expansion and scores every emitted key against the table.
    task automatic run(input int tsel, input logic [127:0] k, input logic rev, input bit rnd,
                       input int inj_at, input bit exp_rev, input int exp_lat, input string tag);
        vec_t e;
        vec_t prev;
        bit   have_prev;
        bit   inj_done;
        int   lowc;
        int   cyc;
        sb.delete();
        for (int i = 0; i < 11; i++) sb.push_back(vt[tsel][exp_rev ? 10 - i : i]);
        key = k;
        reverse = rev;
        round_key_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reverse = 1'b0;
        key = ~k;
        lowc = 0;
        while (!round_key_valid && lowc < 40) begin
            lowc++;
            @(negedge clk);
        end
        chk({tag, " latency"}, 128'(lowc), 128'(exp_lat));
        have_prev = 1'b0;
        inj_done = 1'b0;
        prev = '{4'd0, 128'd0, 1'b0};
        cyc = 0;
        while (sb.size() > 0 && cyc < 300) begin
            start = 1'b0;
            chk({tag, " valid held"}, 128'(round_key_valid), 128'd1);
            if (have_prev) begin
                chk({tag, " stall idx"}, 128'(round_idx), 128'(prev.idx));
                chk({tag, " stall key"}, round_key, prev.rk);
            end
            round_key_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (round_key_ready && round_key_valid) begin
                e = sb.pop_front();
                chk({tag, " idx"}, 128'(round_idx), 128'(e.idx));
                if (e.full) chk({tag, " key"}, round_key, e.rk);
                have_prev = 1'b0;
                if (int'(e.idx) == inj_at && !inj_done) begin
                    start = 1'b1;
                    key = ~k;
                    inj_done = 1'b1;
                end
            end else begin
                have_prev = round_key_valid;
                prev.idx = round_idx;
                prev.rk = round_key;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        round_key_ready = 1'b0;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got %0d keys left expected 0", tag, sb.size());
        end
        chk({tag, " done pulse"}, 128'(done), 128'd1);
        chk({tag, " valid low"}, 128'(round_key_valid), 128'd0);
        chk({tag, " busy low"}, 128'(busy), 128'd0);
        @(negedge clk);
        chk({tag, " done clear"}, 128'(done), 128'd0);
        chk({tag, " stays idle"}, 128'(busy), 128'd0);
    endtask

    initial begin
        int cyc;
        vt[0][0]  = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1};
        vt[0][1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605, 1'b1};
        vt[0][2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f, 1'b1};
        vt[0][3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b, 1'b1};
        vt[0][4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00, 1'b1};
        vt[0][5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc, 1'b1};
        vt[0][6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd, 1'b1};
        vt[0][7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f, 1'b1};
        vt[0][8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f, 1'b1};
        vt[0][9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e, 1'b1};
        vt[0][10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1};
        for (int i = 0; i < 11; i++) vt[1][i] = '{4'(i), 128'd0, 1'b0};
        vt[1][0]  = '{4'd0,  128'h00000000000000000000000000000000, 1'b1};
        vt[1][1]  = '{4'd1,  128'h62636363626363636263636362636363, 1'b1};
        vt[1][2]  = '{4'd2,  128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa, 1'b1};
        vt[1][10] = '{4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        reverse = 1'b0;
        key = '0;
        round_key_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset valid", 128'(round_key_valid), 128'd0);
        chk("reset busy", 128'(busy), 128'd0);
        chk("reset done", 128'(done), 128'd0);
        chk("reset idx", 128'(round_idx), 128'd0);
        chk("reset key", round_key, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run(0, FIPS_KEY, 1'b0, 1'b0, -1, 1'b0, 0, "fips");
        run(0, FIPS_KEY, 1'b0, 1'b1, -1, 1'b0, 0, "bp");
        run(0, FIPS_KEY, 1'b0, 1'b0, 5, 1'b0, 0, "start5");
        run(1, 128'd0, 1'b0, 1'b1, 10, 1'b0, 0, "zero");

        // Reset in the middle of an expansion.
        key = FIPS_KEY;
        round_key_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (round_idx != 4'd3 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("midrst reach idx3", 128'(round_idx), 128'd3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        round_key_ready = 1'b0;
        chk("midrst valid", 128'(round_key_valid), 128'd0);
        chk("midrst busy", 128'(busy), 128'd0);
        chk("midrst idx", 128'(round_idx), 128'd0);
        chk("midrst done", 128'(done), 128'd0);
        @(negedge clk);
        chk("midrst quiet", 128'(round_key_valid), 128'd0);
        run(0, FIPS_KEY, 1'b0, 1'b0, -1, 1'b0, 0, "after_rst");

        run(0, FIPS_KEY, 1'b1, 1'b0, -1, EXP_REV, EXP_REV_LAT, "reverse");
        run(0, FIPS_KEY, 1'b1, 1'b1, -1, EXP_REV, EXP_REV_LAT, "reverse_bp");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
- Sequential AES-128 key expansion. Takes the 128-bit cipher key and produces the 11 round keys, one per handshake, in the order the round datapath consumes them.
- Sits directly upstream of the round-key XOR stage and drives its subkey input.
- Keys are generated on the fly from a single 128-bit working register, so no full key table is needed in the base configuration.

Parameters:
- NR, 10, number of rounds; round keys are indexed 0..NR. Only 10 is supported; elaboration error otherwise.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  request a new expansion; honoured only in IDLE.
- key  input  128  cipher key, sampled on the accepted start; word w0 = key[127:96].
- reverse  input  1  emission order request, sampled with start; honoured only with ROUND_KEY_STORE_EN.
- round_key  output  128  current round key; w0 in bits [127:96].
- round_key_valid  output  1  round_key and round_idx are valid.
- round_key_ready  input  1  consumer accepts the key in the current cycle.
- round_idx  output  4  index of round_key, 0..10.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last key is accepted.

Behaviour:
- Reset (rst_n=0 at a clock edge): FSM goes to IDLE. round_key=0, round_idx=0, round_key_valid=0, busy=0, done=0. Reset mid-operation aborts the expansion with no further outputs.
- FSM states: IDLE, EMIT, PRECALC (PRECALC exists only with ROUND_KEY_STORE_EN).
- IDLE:
  - start=1 at edge t loads round_key=key and round_idx=0, and goes to EMIT.
  - round_key_valid rises in cycle t+1 (one-cycle latency).
  - start while busy is ignored; key is not re-sampled.
- EMIT: round_key_valid=1. round_key and round_idx stay stable until round_key_valid&&round_key_ready.
- On a handshake with round_idx<10:
  - round_key <= next(round_key, rcon[round_idx+1]); round_idx++.
  - Back-to-back handshakes give one key per cycle.
- On a handshake with round_idx==10: round_key_valid drops, done pulses for 1 cycle, FSM returns to IDLE. round_key and round_idx hold their last values.
- next() function, words w0..w3:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}
  - w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
  - RotWord: {b1,b2,b3,b0}. SubWord uses the AES S-box on each byte.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- start asserted in the same cycle as the final handshake is ignored; it must be re-asserted once IDLE is reached.

Optional Feature:
- Macro: AES_KEY_SCHEDULE_ROUND_KEY_STORE_EN.
- With macro: adds an 11x128 register store.
  - start with reverse=0: forward emission as above; each emitted key is also written to the store.
  - start with reverse=1: go to PRECALC with round_key_valid=0. Run 10 silent expansion cycles, one key per cycle, all stored. Then go to EMIT with round_idx=10 and round_key=store[10].
  - In reverse mode, each handshake decrements round_idx and loads store[round_idx-1]. done pulses after the key for index 0 is accepted.
  - Latency from reverse start to first valid: 11 cycles.
- Without macro: no store, no PRECALC state; reverse is ignored and emission is always forward.

Decomposition:
- Shared package aes_pkg holds:
  - constants AES_KEY_W=128, AES_NR=10
  - rcon table function
  - FSM state enum
  - word/byte typedefs
- Sub-module aes_sbox: combinational 8-bit S-box lookup, instantiated 4 times for SubWord. Reusable by the SubBytes stage.

Test Plan:
- FIPS-197 A.1: key=2b7e151628aed2a6abf7158809cf4f3c, ready held 1.
  - Key 0 equals the input key; key 1=a0fafe1788542cb123a339392a6c7605; key 10=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - 11 consecutive valid cycles, then done for 1 cycle.
- Backpressure: same key, ready toggled randomly.
  - round_key and round_idx stay stable while valid&&!ready.
  - Sequence identical to the previous test.
- start pulsed at idx 5 with a different key: ignored, original sequence completes unchanged.
- rst_n=0 at idx 3: next cycle valid=0, busy=0, round_idx=0. A new start then produces key 0 one cycle later.
- Macro on, reverse=1, FIPS key:
  - valid stays low for 10 cycles after the load edge.
  - First key is idx 10 = d014f9a8...ca6; last key is idx 0 = 2b7e1516...4f3c; done follows.
- Macro off, reverse=1: forward order, identical to the first test.
